// File: rtl/polyphase_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : polyphase_mac_if
// Purpose  : Sample, coefficient-load and output handshake bundle for the
//            polyphase interpolation MAC engine.
// Revision : 1.0 - initial release
// ============================================================================
interface polyphase_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int PHASES     = 4,
  parameter int ACC_WIDTH  = 20
);
  localparam int CA_WIDTH = $clog2(TAPS * PHASES);
  localparam int PH_WIDTH = $clog2(PHASES);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;

  logic                         coef_we;
  logic        [CA_WIDTH-1:0]   coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;

  logic                         out_valid;
  logic signed [ACC_WIDTH-1:0]  out_data;
  logic        [PH_WIDTH-1:0]   out_phase;
  logic                         out_ready;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data, out_phase
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data, out_phase
  );
endinterface
`default_nettype wire

// File: rtl/polyphase_mac.sv
`default_nettype none
// ============================================================================
// Module   : polyphase_mac
// Purpose  : Upsample-by-PHASES MAC engine: one accepted sample yields PHASES
//            full-precision outputs, each a TAPS-term dot product.
// Revision : 1.0 - initial release
// ============================================================================
module polyphase_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int PHASES     = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  wire logic       clk,
  input  wire logic       rst,
  polyphase_mac_if.slave  bus
);

  localparam int c_TAP_W  = $clog2(TAPS);
  localparam int c_PH_W   = $clog2(PHASES);
  localparam int c_NCOEF  = TAPS * PHASES;
  localparam int c_PROD_W = DATA_WIDTH + COEF_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                       r_state;
  logic        [c_TAP_W-1:0]    r_wr_ptr;
  logic        [c_TAP_W-1:0]    r_tap;
  logic        [c_PH_W-1:0]     r_phase;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_in_ready;
  logic                         r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_hist [TAPS];

  // The coefficient bank survives rst; it only powers up cleared.
  logic signed [COEF_WIDTH-1:0] r_coef [c_NCOEF] = '{default: '0};

  logic        [c_TAP_W-1:0]    w_hist_idx;
  logic        [c_TAP_W+c_PH_W-1:0] w_coef_idx;
  logic signed [DATA_WIDTH-1:0] w_x;
  logic signed [COEF_WIDTH-1:0] w_c;
  logic signed [c_PROD_W-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic                         w_last_tap;
  logic                         w_last_phase;

  // wr_ptr already points past the newest sample, so x[k] sits k+1 slots back.
  assign w_hist_idx   = r_wr_ptr - c_TAP_W'(1) - r_tap;
  assign w_coef_idx   = {r_phase, r_tap};
  assign w_x          = r_hist[w_hist_idx];
  assign w_c          = r_coef[w_coef_idx];
  assign w_prod       = w_x * w_c;
  assign w_prod_ext   = {{(ACC_WIDTH - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
  assign w_last_tap   = (r_tap == c_TAP_W'(TAPS - 1));
  assign w_last_phase = (r_phase == c_PH_W'(PHASES - 1));

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.coef_we) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_tap       <= '0;
      r_phase     <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_hist[r_wr_ptr] <= bus.in_data;
            r_wr_ptr         <= r_wr_ptr + c_TAP_W'(1);
            r_phase          <= '0;
            r_tap            <= '0;
            r_in_ready       <= 1'b0;
            r_state          <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= (r_tap == '0) ? w_prod_ext : r_acc + w_prod_ext;
          if (w_last_tap) begin
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_tap <= r_tap + c_TAP_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_phase) begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_phase <= r_phase + c_PH_W'(1);
              r_tap   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.out_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_polyphase_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_polyphase_mac
// Purpose  : Directed scoreboard bench for polyphase_mac.
// Revision : 1.0 - initial release
// ============================================================================
module tb_polyphase_mac;
  localparam int DW = 8, CW = 8, TAPS = 4, PHASES = 4, AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  polyphase_mac_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS),
                     .PHASES(PHASES), .ACC_WIDTH(AW)) bus ();

  polyphase_mac #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS),
                  .PHASES(PHASES), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic signed [AW-1:0] data;
    logic        [1:0]    phase;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_total++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got data=%0d phase=%0d expected none",
                 bus.out_data, bus.out_phase);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.out_data !== e.data || bus.out_phase !== e.phase) begin
          n_bad++;
          $display("FAIL scoreboard: got data=%0d phase=%0d expected data=%0d phase=%0d",
                   bus.out_data, bus.out_phase, e.data, e.phase);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input int p);
    exp_t e;
    e.data  = AW'(v);
    e.phase = 2'(p);
    q.push_back(e);
  endtask

  task automatic push4(input int v0, input int v1, input int v2, input int v3);
    push(v0, 0); push(v1, 1); push(v2, 2); push(v3, 3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
  endtask

  task automatic write_coef(input int addr, input int data);
    wait_ready();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = CW'(data);
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic load_identity();
    for (int i = 0; i < TAPS * PHASES; i++) write_coef(i, (i == 0) ? 1 : 0);
  endtask

  // Drives one sample (optionally with a same-cycle coefficient write) and
  // returns right after the acceptance edge.
  task automatic accept(input int sample, input bit cw, input int caddr, input int cdata);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(sample);
    bus.coef_we   = cw;
    bus.coef_addr = 4'(caddr);
    bus.coef_data = CW'(cdata);
    tick();
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
  endtask

  task automatic drain(input string name);
    wait_ready();
    check(name, q.size(), 0);
  endtask

  task automatic send(input int sample, input int e0, input int e1, input int e2, input int e3);
    push4(e0, e1, e2, e3);
    accept(sample, 1'b0, 0, 0);
    drain("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;

    do_reset();
    check("reset_in_ready",  bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data",  bus.out_data, 0);
    check("reset_out_phase", bus.out_phase, 0);

    // Identity filter, with latency and per-input period on the first sample
    load_identity();
    push4(5, 0, 0, 0);
    accept(5, 1'b0, 0, 0);
    n = 1;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    check("first_output_latency", n, TAPS + 1);
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    check("input_period", n, PHASES * (TAPS + 1) + 1);
    drain("identity_5");
    send(-3, -3, 0, 0, 0);
    send(7, 7, 0, 0, 0);

    // Impulse response reads the coefficient bank column by column
    do_reset();
    for (int i = 0; i < 16; i++) write_coef(i, i + 1);
    send(1, 1, 5, 9, 13);
    send(0, 2, 6, 10, 14);
    send(0, 3, 7, 11, 15);
    send(0, 4, 8, 12, 16);

    // Backpressure on the phase-1 output: history is now [3,0,0,0]
    push4(3, 15, 27, 39);
    accept(3, 1'b0, 0, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_phase == 2'd1) && n < 50) begin tick(); n++; end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data",  bus.out_data, 15);
      check("bp_out_phase", bus.out_phase, 1);
      check("bp_in_ready",  bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    drain("bp_resume");

    // Extremes
    do_reset();
    for (int i = 0; i < 16; i++) write_coef(i, -128);
    send(-128, 16384, 16384, 16384, 16384);
    send(-128, 32768, 32768, 32768, 32768);
    send(-128, 49152, 49152, 49152, 49152);
    send(-128, 65536, 65536, 65536, 65536);
    send(127, 32896, 32896, 32896, 32896);
    send(127, 256, 256, 256, 256);
    send(127, -32384, -32384, -32384, -32384);
    send(127, -65024, -65024, -65024, -65024);

    // Coefficient writes held across MAC/OUT must be ignored
    do_reset();
    load_identity();
    push4(4, 0, 0, 0);
    accept(4, 1'b0, 0, 0);
    bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 8'sd50;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    bus.coef_we = 1'b0;
    drain("busy_write_4");
    send(6, 6, 0, 0, 0);
    write_coef(0, 50);
    send(2, 100, 0, 0, 0);
    // Write coinciding with acceptance applies to that sample
    push4(50, 2, 0, 0);
    accept(1, 1'b1, 4, 2);
    drain("accept_write");

    // Reset during phase-2 MAC; history is [8,1,2,6] so x[1] feeds phase 0
    write_coef(0, 1);
    write_coef(1, 1);
    write_coef(4, 0);
    push(9, 0);
    push(0, 1);
    accept(8, 1'b0, 0, 0);
    n = 0;
    while (!(bus.out_phase == 2'd2 && !bus.out_valid) && n < 50) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    check("midrst_no_output", cnt, 0);
    check("midrst_queue", q.size(), 0);
    send(9, 9, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/polyphase_mac.md
# polyphase_mac

Polyphase interpolation MAC engine for the interpolation filter datapath. It accepts one input sample per handshake and stores it in a small circular sample history. It then produces PHASES output samples, one per polyphase sub-filter, each a TAPS-term signed multiply-accumulate against a loadable coefficient bank. It sits downstream of the sample delay line and upstream of the output formatter, and implements upsampling by PHASES.

## Interface
- DATA_WIDTH, 8, signed input sample width
- COEF_WIDTH, 8, signed coefficient width
- TAPS, 4, taps per phase (power of 2, ≥2)
- PHASES, 4, interpolation factor L (power of 2, ≥2)
- ACC_WIDTH, 20, accumulator/output width; must be ≥ DATA_WIDTH+COEF_WIDTH+log2(TAPS)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample present
- in_data  in  DATA_WIDTH  signed input sample
- in_ready  out  1  engine can accept a sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS*PHASES)  coefficient index = phase*TAPS + tap
- coef_data  in  COEF_WIDTH  signed coefficient
- out_valid  out  1  output sample present
- out_data  out  ACC_WIDTH  signed filtered output, full precision
- out_phase  out  log2(PHASES)  phase index of out_data
- out_ready  in  1  downstream accepts output

## Operation
- Sample history: TAPS entries, circular, write pointer wr_ptr. x[0] = newest accepted sample, x[k] = k-th older sample.
- FSM states:
  - IDLE: in_ready=1. On in_valid, write in_data at wr_ptr, advance wr_ptr (wraps modulo TAPS), set phase=0, tap=0, go to MAC.
  - MAC: one product per cycle. tap=0 loads acc = coef[phase*TAPS+0]*x[0]. Each later tap does acc += coef[phase*TAPS+k]*x[k]. After tap=TAPS-1, go to OUT.
  - OUT: out_valid=1, out_data=acc, out_phase=phase, all held stable. On out_ready: if phase==PHASES-1, go to IDLE; else phase+1, tap=0, go to MAC.
- Arithmetic: products are signed, full width, sign-extended to ACC_WIDTH. No rounding, truncation or saturation.
- Coefficients: write-only port. coef_we is honoured only in IDLE and ignored in MAC/OUT. A write in the same cycle as an input acceptance is honoured and applies to that sample.
- Coefficients are not cleared by rst. Their power-up value is 0.
- Sample history contents are cleared to 0 by rst.

## Timing
- Reset values: in_ready=1 from the first cycle after rst deasserts, out_valid=0, out_data=0, out_phase=0, wr_ptr=0, state IDLE, history all 0.
- rst asserted in any state (including mid-MAC or OUT with a pending output) aborts the current computation. The pending output is dropped, with no out_valid in the cycle after the reset edge.
- Acceptance edge A: MAC occupies the next TAPS cycles. out_valid rises in cycle A+TAPS+1 (5 cycles after A with defaults).
- With out_ready held high, each phase costs TAPS+1 cycles. One input costs PHASES*(TAPS+1) cycles, then the FSM returns to IDLE. in_ready reasserts the cycle after the final output handshake.
- in_ready is a registered function of state. in_ready=0 in MAC and OUT, and in_data is ignored there.
- out_valid never drops without an out_ready handshake (except on rst).

## Test plan
- Identity: coef[0]=1, all other coefficients 0; feed 5, -3, 7 → phase-0 outputs 5, -3, 7; phases 1..3 output 0; 4 outputs per input.
- Impulse response: coef[i]=i+1 for i=0..15; feed 1 then three 0s → outputs, in order: (1,5,9,13), (2,6,10,14), (3,7,11,15), (4,8,12,16) with out_phase cycling 0..3.
- Extremes: all coefficients -128, four inputs of -128 → fourth input's outputs all +65536 with no overflow in 20 bits. Repeat with inputs +127 → each output -65024.
- Backpressure: hold out_ready low for 5 cycles at the phase-1 output → out_valid, out_data and out_phase stay stable; in_ready stays 0; the sequence resumes after the handshake.
- Coefficient write in MAC/OUT: write coef[0]=50 while in MAC → ignored; the next input still uses the old value. The same write in IDLE takes effect.
- Reset mid-operation: assert rst during MAC of phase 2 → no further out_valid; in_ready=1 the cycle after rst deasserts. The next input 9 with the identity coefficients produces 9 (history cleared, older taps contribute 0).
